// File: rtl/vector_video_pkg.sv
// Shared types and constants for the Vector-06C video fetch path.
// Plane bytes live at {VRAM_BASE_BIT, plane, col, row} in SRAM page 0.
package vector_video_pkg;

  localparam int PLANE_COUNT = 4;
  localparam int COL_W       = 5;
  localparam int ROW_W       = 8;

  localparam logic VRAM_BASE_BIT = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    READ = ST_READ,
    DONE = ST_DONE
  } fetch_state_e;

  // Low 16 address bits of one plane byte; callers zero-extend to the bus width.
  function automatic logic [15:0] plane_addr(input logic [1:0]       plane,
                                             input logic [COL_W-1:0] col,
                                             input logic [ROW_W-1:0] row);
    return {VRAM_BASE_BIT, plane, col, row};
  endfunction

endpackage

// File: rtl/sram_fetch_pending.sv
// One-deep request buffer between the video timing and the fetch FSM.
// `VIDEO_VSCROLL_EN also stores the scroll offset sampled with the request.
module sram_fetch_pending
  import vector_video_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             consume,
  input  logic [COL_W-1:0] col_in,
  input  logic [ROW_W-1:0] row_in,
`ifdef VIDEO_VSCROLL_EN
  input  logic [ROW_W-1:0] vscroll_in,
  output logic [ROW_W-1:0] pend_vscroll,
`endif
  output logic             pend_valid,
  output logic [COL_W-1:0] pend_col,
  output logic [ROW_W-1:0] pend_row,
  output logic             overrun
);

  logic accept;

  // A full buffer still accepts when the FSM drains it on the same edge.
  assign accept = load && (!pend_valid || consume);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid   <= 1'b0;
      pend_col     <= '0;
      pend_row     <= '0;
      overrun      <= 1'b0;
`ifdef VIDEO_VSCROLL_EN
      pend_vscroll <= '0;
`endif
    end else begin
      if (accept) begin
        pend_valid   <= 1'b1;
        pend_col     <= col_in;
        pend_row     <= row_in;
`ifdef VIDEO_VSCROLL_EN
        pend_vscroll <= vscroll_in;
`endif
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
      if (load && !accept) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_video_fetch.sv
// Video read client: arbitrates for the SRAM and returns four plane bytes per request.
// `VIDEO_VSCROLL_EN adds the vscroll input, added to the row modulo 256.
module sram_video_fetch
  import vector_video_pkg::*;
#(
  parameter int READ_WAIT = 2,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [COL_W-1:0]  fetch_col,
  input  logic [ROW_W-1:0]  fetch_row,
`ifdef VIDEO_VSCROLL_EN
  input  logic [ROW_W-1:0]  vscroll,
`endif
  output logic              sram_req,
  input  logic              sram_gnt,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_oe_n,
  input  logic [7:0]        sram_dq_in,
  output logic [31:0]       video_word,
  output logic              word_valid,
  output logic              busy,
  output logic              overrun
);

  // state | meaning
  // IDLE  | nothing in flight, waiting for a pending request
  // REQ   | requesting the bus (also re-entered after grant loss)
  // READ  | OE low, walking planes 0..3, READ_WAIT cycles each
  // DONE  | video_word updated, word_valid high for this cycle

  localparam logic [2:0] WAIT_RELOAD = 3'(READ_WAIT - 1);

  fetch_state_e     state;
  logic [COL_W-1:0] work_col;
  logic [ROW_W-1:0] work_row;
  logic [1:0]       plane;
  logic [2:0]       wcnt;
  logic [7:0]       byte0, byte1, byte2;

  logic             pend_valid;
  logic             consume;
  logic [COL_W-1:0] pend_col;
  logic [ROW_W-1:0] pend_row;
  logic [ROW_W-1:0] start_row;

`ifdef VIDEO_VSCROLL_EN
  logic [ROW_W-1:0] pend_vscroll;
  assign start_row = pend_row + pend_vscroll;
`else
  assign start_row = pend_row;
`endif

  assign consume = pend_valid && (state == IDLE || state == DONE);

  sram_fetch_pending u_pending (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (fetch_req),
    .consume      (consume),
    .col_in       (fetch_col),
    .row_in       (fetch_row),
`ifdef VIDEO_VSCROLL_EN
    .vscroll_in   (vscroll),
    .pend_vscroll (pend_vscroll),
`endif
    .pend_valid   (pend_valid),
    .pend_col     (pend_col),
    .pend_row     (pend_row),
    .overrun      (overrun)
  );

  assign sram_req  = (state == REQ) || (state == READ);
  assign sram_oe_n = (state != READ);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      work_col   <= '0;
      work_row   <= '0;
      plane      <= '0;
      wcnt       <= '0;
      byte0      <= '0;
      byte1      <= '0;
      byte2      <= '0;
      sram_addr  <= '0;
      video_word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_valid) begin
            state    <= REQ;
            work_col <= pend_col;
            work_row <= start_row;
          end
        end
        REQ: begin
          if (sram_gnt) begin
            state     <= READ;
            plane     <= 2'd0;
            wcnt      <= WAIT_RELOAD;
            sram_addr <= ADDR_W'(plane_addr(2'd0, work_col, work_row));
          end
        end
        READ: begin
          // Losing the bus discards partial bytes; the fetch restarts at plane 0.
          if (!sram_gnt) begin
            state <= REQ;
            plane <= 2'd0;
          end else if (wcnt != 3'd0) begin
            wcnt <= wcnt - 3'd1;
          end else if (plane == 2'd3) begin
            video_word <= {sram_dq_in, byte2, byte1, byte0};
            word_valid <= 1'b1;
            state      <= DONE;
            plane      <= 2'd0;
          end else begin
            case (plane)
              2'd0:    byte0 <= sram_dq_in;
              2'd1:    byte1 <= sram_dq_in;
              default: byte2 <= sram_dq_in;
            endcase
            plane     <= plane + 2'd1;
            wcnt      <= WAIT_RELOAD;
            sram_addr <= ADDR_W'(plane_addr(plane + 2'd1, work_col, work_row));
          end
        end
        DONE: begin
          if (pend_valid) begin
            state    <= REQ;
            work_col <= pend_col;
            work_row <= start_row;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
